// File: rtl/spi_regfile_ctrl.sv
// spi_regfile_ctrl
//
// SPI slave (mode 0, MSB first) in front of a parametrised register bank.
// A frame is a command word, an address word, and then any number of data
// words. Write frames commit each data word to a read/write register. Read
// frames return register contents on MISO. Burst auto-increment is chosen by
// the command word. Out-of-range accesses set a sticky per-frame error flag.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   SCK, CS      SPI clock and active-low chip select (asynchronous to clk)
//   MOSI, MISO   SPI data in / out
//   regwr_bus    flattened read/write registers, reg i at [i*DATA_W +: DATA_W]
//   regr_bus     flattened read-only inputs, reg j at [j*DATA_W +: DATA_W]
//   wr_stb       one-clk pulse per committed register write
//   wr_addr      address of the last committed write
//   frame_done   one-clk pulse after CS deasserts on an active frame
//   err          out-of-range / illegal access seen in the current frame
module spi_regfile_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_WR   = 121,
  parameter int N_RD   = 1,
  localparam int N_TOT  = N_WR + N_RD,
  localparam int ADDR_W = $clog2(N_WR + N_RD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SCK,
  input  logic                     CS,
  input  logic                     MOSI,
  output logic                     MISO,
  output logic [N_WR*DATA_W-1:0]   regwr_bus,
  input  logic [N_RD*DATA_W-1:0]   regr_bus,
  output logic                     wr_stb,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     frame_done,
  output logic                     err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(N_TOT - 1);
  localparam logic [ADDR_W:0]   N_WR_A  = (ADDR_W + 1)'(N_WR);
  localparam logic [ADDR_W:0]   N_TOT_A = (ADDR_W + 1)'(N_TOT);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  // ---------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------
  // Everything resets to 0. If CS is already low when reset releases, no CS
  // fall is seen, so the rest of an interrupted frame is ignored.
  logic [1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic       sck_prev_reg, cs_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= 1'b0;
      cs_prev_reg   <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[0], SCK};
      cs_sync_reg   <= {cs_sync_reg[0], CS};
      mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
      sck_prev_reg  <= sck_sync_reg[1];
      cs_prev_reg   <= cs_sync_reg[1];
    end
  end

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  assign sck_rise = sck_sync_reg[1] & ~sck_prev_reg;
  assign sck_fall = ~sck_sync_reg[1] & sck_prev_reg;
  assign cs_rise  = cs_sync_reg[1] & ~cs_prev_reg;
  assign cs_fall  = ~cs_sync_reg[1] & cs_prev_reg;
  assign mosi_s   = mosi_sync_reg[1];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t              state_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [DATA_W-2:0]   rx_reg;        // the top bit is never needed after shifting
  logic [DATA_W-1:0]   tx_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                is_wr_reg, inc_reg, bad_addr_reg, commit_reg;
  logic [DATA_W-1:0]   regs_reg [N_WR];

  // Read view over both register kinds, indexed by the bus address.
  logic [DATA_W-1:0]   word_arr [N_TOT];

  generate
    for (genvar gi = 0; gi < N_WR; gi++) begin : g_wr
      assign regwr_bus[gi*DATA_W +: DATA_W] = regs_reg[gi];
      assign word_arr[gi] = regs_reg[gi];
    end
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
      assign word_arr[N_WR + gi] = regr_bus[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [DATA_W-1:0] rx_next;
  logic              last_bit;
  logic [ADDR_W-1:0] addr_adv;
  logic              addr_in_wr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oob;
  logic [DATA_W-1:0] rd_word;

  assign rx_next    = {rx_reg, mosi_s};
  assign last_bit   = (bit_cnt_reg == CNT_W'(DATA_W - 1));
  assign addr_adv   = !inc_reg ? addr_reg :
                      (addr_reg == LAST_A) ? '0 : addr_reg + ADDR_W'(1);
  assign addr_in_wr = ({1'b0, addr_reg} < N_WR_A);

  // Read source: the address word itself on the address load, otherwise the
  // advanced burst address. Nonzero upper address bits poison the frame.
  always_comb begin
    rd_addr = addr_adv;
    rd_oob  = bad_addr_reg;
    if (state_reg == ADDR) begin
      rd_addr = rx_next[ADDR_W-1:0];
      rd_oob  = (rx_next[DATA_W-1:ADDR_W] != '0);
    end
    if ({1'b0, rd_addr} >= N_TOT_A) rd_oob = 1'b1;
    rd_word = '0;
    for (int i = 0; i < N_TOT; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = word_arr[i];
    end
    if (rd_oob) rd_word = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_reg       <= '0;
      tx_reg       <= '0;
      wdata_reg    <= '0;
      addr_reg     <= '0;
      is_wr_reg    <= 1'b0;
      inc_reg      <= 1'b0;
      bad_addr_reg <= 1'b0;
      commit_reg   <= 1'b0;
      MISO         <= 1'b0;
      wr_stb       <= 1'b0;
      wr_addr      <= '0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < N_WR; i++) regs_reg[i] <= '0;
    end else begin
      wr_stb     <= 1'b0;
      frame_done <= 1'b0;

      // A completed data word commits one cycle after its last bit, even if
      // CS rises in that cycle: the word was already whole.
      if (commit_reg) begin
        commit_reg <= 1'b0;
        if (addr_in_wr && !bad_addr_reg) begin
          for (int i = 0; i < N_WR; i++) begin
            if (addr_reg == ADDR_W'(i)) regs_reg[i] <= wdata_reg;
          end
          wr_stb  <= 1'b1;
          wr_addr <= addr_reg;
        end else begin
          err <= 1'b1;
        end
        addr_reg <= addr_adv;
      end

      if (cs_rise) begin
        // CS rise has priority over a coincident last-bit rise: drop the word.
        frame_done  <= (state_reg != IDLE);
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        tx_reg      <= '0;
        MISO        <= 1'b0;
      end else if (cs_fall) begin
        state_reg    <= CMD;
        bit_cnt_reg  <= '0;
        tx_reg       <= '0;
        MISO         <= 1'b0;
        is_wr_reg    <= 1'b0;
        inc_reg      <= 1'b0;
        bad_addr_reg <= 1'b0;
        err          <= 1'b0;
      end else if (state_reg != IDLE) begin
        if (sck_fall) begin
          if (state_reg == DATA && !is_wr_reg) begin
            MISO   <= tx_reg[DATA_W-1];
            tx_reg <= tx_reg << 1;
          end else begin
            MISO <= 1'b0;
          end
        end
        if (sck_rise) begin
          rx_reg      <= rx_next[DATA_W-2:0];
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (last_bit) begin
            bit_cnt_reg <= '0;
            case (state_reg)
              CMD: begin
                is_wr_reg <= rx_next[DATA_W-1];
                inc_reg   <= rx_next[DATA_W-2];
                state_reg <= ADDR;
              end
              ADDR: begin
                addr_reg <= rx_next[ADDR_W-1:0];
                if (rx_next[DATA_W-1:ADDR_W] != '0) begin
                  bad_addr_reg <= 1'b1;
                  err          <= 1'b1;
                end
                if (!is_wr_reg) begin
                  tx_reg <= rd_word;
                  if (rd_oob) err <= 1'b1;
                end
                state_reg <= DATA;
              end
              DATA: begin
                if (is_wr_reg) begin
                  wdata_reg  <= rx_next;
                  commit_reg <= 1'b1;
                end else begin
                  // Reads advance first, then load the word for the next slot.
                  addr_reg <= addr_adv;
                  tx_reg   <= rd_word;
                  if (rd_oob) err <= 1'b1;
                end
              end
              default: state_reg <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule
